// File: rtl/alu_pkg.sv
// Shared op codes and stage FSM encoding for the ALU execute stage.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SLL  = 4'd4;
    localparam logic [3:0] OP_SRL  = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_NOR  = 4'd8;
    localparam logic [3:0] OP_LUI  = 4'd9;
    localparam logic [3:0] OP_ADDU = 4'd10;
    localparam logic [3:0] OP_SUBU = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_exec_stage_if.sv
// Request/response bundle between the ALU control side and the exec stage.
interface alu_exec_stage_if #(parameter int WIDTH = 32);

    logic             InValid;
    logic             InReady;
    logic [3:0]       OperationALU;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [4:0]       Shamt;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] Result;
    logic             Zero;
    logic             Overflow;

    modport master (
        output InValid, OperationALU, A, B, Shamt, OutReady,
        input  InReady, OutValid, Result, Zero, Overflow
    );

    modport slave (
        input  InValid, OperationALU, A, B, Shamt, OutReady,
        output InReady, OutValid, Result, Zero, Overflow
    );

endinterface

// File: rtl/alu_core.sv
// Single-cycle combinational ALU ops. Shifts are sequenced by the stage and
// give 0 here; unused codes also give 0.
import alu_pkg::*;

module alu_core #(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    // Op decode; signed overflow only for the trapping add/sub.
    always_comb begin
        result   = '0;
        overflow = 1'b0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD: begin
                result   = sum;
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result   = diff;
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_NOR:  result = ~(a | b);
            OP_LUI:  result = {b[15:0], {(WIDTH-16){1'b0}}};
            OP_ADDU: result = sum;
            OP_SUBU: result = diff;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: valid/ready handshake, one-bit-per-cycle shifter for
// SLL/SRL, and a registered result held until the consumer takes it.
import alu_pkg::*;

module alu_exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    alu_exec_stage_if.slave   bus
);

    state_t           state;
    state_t           state_nxt;
    logic             in_ready;
    logic             accept;
    logic             is_shift;
    logic             start_shift;
    logic             cnt_last;
    logic [4:0]       cnt;
    logic             shl;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_nxt;
    logic [WIDTH-1:0] core_res;
    logic             core_ovf;
    logic [WIDTH-1:0] imm_res;
    logic [WIDTH-1:0] res_q;
    logic             zero_q;
    logic             ovf_q;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op       (bus.OperationALU),
        .a        (bus.A),
        .b        (bus.B),
        .result   (core_res),
        .overflow (core_ovf)
    );

    // In DONE a new request may ride on the same edge the result is taken.
    assign in_ready    = (state == ST_IDLE) || ((state == ST_DONE) && bus.OutReady);
    assign accept      = bus.InValid && in_ready;
    assign is_shift    = (bus.OperationALU == OP_SLL) || (bus.OperationALU == OP_SRL);
    assign start_shift = accept && is_shift && (bus.Shamt != 5'd0);
    assign cnt_last    = (cnt == 5'd1);
    assign work_nxt    = shl ? (work << 1) : (work >> 1);
    // A zero-distance shift is just a pass-through of B.
    assign imm_res     = is_shift ? bus.B : core_res;

    assign bus.InReady  = in_ready;
    assign bus.OutValid = (state == ST_DONE);
    assign bus.Result   = res_q;
    assign bus.Zero     = zero_q;
    assign bus.Overflow = ovf_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state; requests arriving while shifting are dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = start_shift ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                if (cnt_last) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (accept)            state_nxt = start_shift ? ST_SHIFT : ST_DONE;
                else if (bus.OutReady) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: capture immediate results or step the shifter.
    always_ff @(posedge clk) begin
        if (rst) begin
            work   <= '0;
            cnt    <= '0;
            shl    <= 1'b0;
            res_q  <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (accept) begin
            if (start_shift) begin
                work <= bus.B;
                cnt  <= bus.Shamt;
                shl  <= (bus.OperationALU == OP_SLL);
            end else begin
                res_q  <= imm_res;
                zero_q <= (imm_res == '0);
                ovf_q  <= is_shift ? 1'b0 : core_ovf;
            end
        end else if (state == ST_SHIFT) begin
            work <= work_nxt;
            cnt  <= cnt - 5'd1;
            if (cnt_last) begin
                res_q  <= work_nxt;
                zero_q <= (work_nxt == '0);
                ovf_q  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL use one clock and one reset: reset is synchronous and active-high.
REQ-002 Parameter: WIDTH, default 32, datapath width.
REQ-003 Clock  input  1  rising-edge clock for all state.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 InValid  input  1  operation request present.
REQ-006 InReady  output  1  stage can accept a request this cycle.
REQ-007 OperationALU  input  4  operation code from ALU control.
REQ-008 A  input  WIDTH  first operand.
REQ-009 B  input  WIDTH  second operand; shift source for SLL/SRL.
REQ-010 Shamt  input  5  shift amount.
REQ-011 OutValid  output  1  Result/Zero/Overflow valid.
REQ-012 OutReady  input  1  consumer takes result this cycle.
REQ-013 Result  output  WIDTH  registered result.
REQ-014 Zero  output  1  Result equals zero.
REQ-015 Overflow  output  1  signed overflow of ADD/SUB.

Function
REQ-016 Op codes SHALL be: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLL, 5 SRL, 6 XOR, 7 SLT (signed, result 1/0), 8 NOR, 9 LUI (B[15:0]<<16), 10 ADDU, 11 SUBU.
REQ-017 Codes 12-15 SHALL give Result 0, Zero 1, Overflow 0.
REQ-018 States SHALL be IDLE, SHIFT, DONE.
REQ-019 InReady SHALL be 1 in IDLE, equal OutReady in DONE, 0 in SHIFT.
REQ-020 Accept occurs on a rising edge with InValid and InReady both 1; inputs are sampled only at that edge.
REQ-021 Non-shift op or shift with Shamt 0: Result, Zero, and Overflow are registered at the accept edge, the state goes to DONE, and OutValid is 1 in the next cycle (latency 1).
REQ-022 Shift with Shamt N>0: the accept edge loads a work register with B and the counter with N, and the state goes to SHIFT.
REQ-023 In SHIFT, each edge shifts the work register by one bit (SLL left, SRL logical right, zero fill) and decrements the counter.
REQ-024 The state SHALL go to DONE on the edge where the counter is 1, so OutValid is 1 exactly N+1 cycles after the accept edge.
REQ-025 Overflow SHALL be 1 only for op 2/3 when the operand signs are such that the result sign is wrong; it is 0 for 10/11 and all other ops.
REQ-026 In DONE, outputs SHALL hold stable until OutValid and OutReady are both 1.
REQ-027 On that OutValid/OutReady edge: if InValid is also 1, the new request is accepted (back-to-back); otherwise the state goes to IDLE and OutValid goes to 0.
REQ-028 InValid during SHIFT SHALL be ignored and not queued.
REQ-029 Adds/subtracts SHALL wrap modulo 2^WIDTH; SLT SHALL compare signed, with no overflow side effect.

Reset
REQ-030 Reset SHALL force: state IDLE, OutValid 0, InReady 1 in the following cycle, Result 0, Zero 0, Overflow 0, counter 0, work register 0.
REQ-031 Reset mid-SHIFT or in DONE SHALL discard the operation; no OutValid is produced for it.
REQ-032 Reset SHALL take priority over any simultaneous accept or handshake.

Structure
REQ-033 Package alu_pkg SHALL hold the op-code localparams (values of REQ-016) and the state encoding.
REQ-034 Combinational ops (all except shifts) SHALL sit in sub-module alu_core; the handshake FSM, counter, and shift register stay in alu_exec_stage.

Verification
REQ-035 ADD: A=0x7FFFFFFF, B=1, op 2, OutReady 1 -> next cycle OutValid 1, Result 0x80000000, Overflow 1, Zero 0.
REQ-036 SUBU: A=5, B=5, op 11 -> Result 0, Zero 1, Overflow 0, latency 1.
REQ-037 SLL: B=0x00000001, Shamt 31, op 4 -> InReady 0 for 31 cycles, OutValid at cycle 32, Result 0x80000000.
REQ-038 Backpressure: SLT with A=-1, B=0 and OutReady 0 for 3 cycles -> Result 1 held stable; InValid 1 with OutReady raised -> next op accepted on the same edge.
REQ-039 Reset asserted mid-SRL (Shamt 10, cycle 4) -> OutValid never rises for it, and outputs are 0 after reset.
REQ-040 Op 13 -> Result 0, Zero 1; Shamt 0 SRL with B=0xF0 -> Result 0xF0 at latency 1.
